i2c_req_arb: RTL and testbench
==============================

// Module: i2c_req_arb
// PURPOSE
//  Upstream requester stage for i2c_sys_top. Arbitrates two client ports (client 0 = domain 0, client 1 = domain 1) round-robin.
//  Enforces a per-domain slave-address allow rule, then issues one start/slave_addr/domain_i2c transaction downstream.
//  Waits for done, captures read_data and returns it only to the granting client. A watchdog latches a fault if done never arrives.
// PARAMETERS
//  SADDR_D0   7'b0010_000  only slave address client 0 may access
//  SADDR_D1   7'b0100_000  only slave address client 1 may access
//  TO_W       16           watchdog counter width
//  TO_CYC     16'd50000    WAIT cycles before timeout (>=2)
// PORTS
//  clk          in   1  system clock, all logic posedge
//  rst_n        in   1  asynchronous, active-low reset
//  req0/req1    in   1  client request, level; held until ackN or errN
//  saddr0/1     in   7  client slave address, stable while reqN=1
//  ack0/ack1    out  1  1-cycle pulse: read complete, rdataN valid
//  err0/err1    out  1  1-cycle pulse: request denied or timed out
//  rdata0/1     out  8  read byte; valid only with ackN, else 8'h00
//  start        out  1  1-cycle pulse to i2c_sys_top
//  slave_addr   out  7  to i2c_sys_top; held GRANT..WAIT, else 7'h00
//  domain_i2c   out  1  granted client index; held GRANT..WAIT, else 0
//  done         in   1  1-cycle completion pulse from i2c_sys_top
//  read_data    in   8  i2c_sys_top read_data_out, sampled when done=1
//  busy         out  1  1 in any state other than IDLE
//  hung         out  1  sticky watchdog fault flag
// BEHAVIOUR
//  - Reset: all outputs 0; state=IDLE; rr_last=1, so client 0 wins the first tie; watchdog=0; capture reg=0.
//  - FSM: IDLE, CHECK, GRANT, WAIT, RESP, DENY, FAULT.
//  - IDLE: if any reqN, pick the winner. When both request, the winner is the client != rr_last.
//    Latch winner index and saddr; go to CHECK. done is ignored in IDLE.
//  - CHECK: if latched saddr == SADDR_D<winner>, go to GRANT; else go to DENY. rr_last <= winner in both cases.
//  - GRANT: start=1 for exactly this cycle; slave_addr/domain_i2c driven. Watchdog cleared; go to WAIT.
//  - WAIT: slave_addr/domain_i2c held; watchdog increments each cycle.
//    On done=1: capture read_data; go to RESP.
//    If watchdog == TO_CYC-1 and done=0: go to FAULT. done in the same cycle as expiry wins (normal RESP).
//  - RESP: ack<winner>=1 and rdata<winner>=captured byte for one cycle; the other client's ack/rdata stay 0. Go to IDLE.
//  - DENY: err<winner>=1 for one cycle, rdata 0, downstream never touched; go to IDLE.
//  - FAULT: err<winner>=1 on the entry cycle only; hung=1 and busy=1 until reset. All reqN ignored, start never reasserted.
//  - Latency, permitted request: req in IDLE -> start 2 cycles later -> ack 1 cycle after the done cycle.
//  - Latency, denied request: req -> err 2 cycles later.
//  - Clients must drop reqN the cycle after ackN/errN. IDLE re-samples on the cycle after RESP/DENY, giving a minimum 1-cycle gap between transactions.
//  - Isolation: captured byte never drives the non-winner's rdata. Capture reg is cleared to 0 on entry to IDLE.
//  - reqN changing mid-transaction has no effect on the latched winner or saddr.
//  - rst_n low at any point: immediate return to reset values, including clearing hung.
// TESTING
//  - Single permitted read: req0=1, saddr0=7'h10, done pulse 5 cycles after start with read_data=8'hA5 ->
//    one start pulse, slave_addr=7'h10, domain_i2c=0, then ack0=1 with rdata0=8'hA5 and rdata1=8'h00.
//  - Denied access: req1=1, saddr1=7'h10 -> err1 pulse 2 cycles later; start never asserted; ack1=0.
//  - Tie and round-robin: req0 and req1 both held (7'h10 / 7'h20) from reset ->
//    client 0 served first, then client 1, with domain_i2c=1 on the second start; repeat alternates 0,1,0,1.
//  - Watchdog: TO_CYC=8, permitted request, no done -> err pulse at WAIT cycle 8, hung=1.
//    A later req1 gives no start; hung=1 until rst_n.
//  - Done/timeout collision: TO_CYC=8, done on the expiry cycle -> normal ack, hung stays 0.
//  - Reset mid-WAIT: assert rst_n=0 during WAIT -> all outputs 0 next edge; after release a fresh req0 completes normally.

Source files
------------

// File: rtl/i2c_req_arb_if.sv
// Purpose: bundles the client request/response signals and the downstream
//   i2c_sys_top command/completion signals of the requester stage.
// Ports: client side req/saddr in, ack/err/rdata out; downstream start/slave_addr/domain_i2c out,
//   done/read_data in; status busy/hung out. slave = arbiter view, master = environment view.
interface i2c_req_arb_if;
  logic       req0;
  logic       req1;
  logic [6:0] saddr0;
  logic [6:0] saddr1;
  logic       ack0;
  logic       ack1;
  logic       err0;
  logic       err1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic       start;
  logic [6:0] slave_addr;
  logic       domain_i2c;
  logic       done;
  logic [7:0] read_data;
  logic       busy;
  logic       hung;

  modport slave (
    input  req0, req1, saddr0, saddr1, done, read_data,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output start, slave_addr, domain_i2c, busy, hung
  );

  modport master (
    output req0, req1, saddr0, saddr1, done, read_data,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  start, slave_addr, domain_i2c, busy, hung
  );
endinterface

// File: rtl/i2c_req_arb.sv
// Purpose: round-robin arbiter for two clients in front of i2c_sys_top. It checks each client's
//   slave address against that client's domain, issues one downstream transaction, returns the
//   read byte to the granted client only, and latches a sticky fault if done never arrives.
// Ports: clk, rst_n (async active-low); bus (slave modport): client req/saddr/ack/err/rdata,
//   downstream start/slave_addr/domain_i2c/done/read_data, status busy/hung.
// Latency: req -> start 2 cycles, done -> ack 1 cycle; req -> err 2 cycles when denied.
module i2c_req_arb #(
  parameter logic [6:0]      SADDR_D0 = 7'b0010_000,
  parameter logic [6:0]      SADDR_D1 = 7'b0100_000,
  parameter int              TO_W     = 16,
  parameter logic [TO_W-1:0] TO_CYC   = 16'd50000
) (
  input logic           clk,
  input logic           rst_n,
  i2c_req_arb_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, CHECK, GRANT, WAIT, RESP, DENY, FAULT
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_CYC - TO_W'(1);

  state_t          state;
  logic            rr_last;   // client served (or denied) most recently
  logic            win;       // latched winner index
  logic [6:0]      saddr_q;   // latched winner slave address
  logic [TO_W-1:0] wd;
  logic [7:0]      cap;
  logic            start_q;
  logic            ack0_q, ack1_q, err0_q, err1_q;
  logic            busy_q, hung_q;
  logic [6:0]      sa_q;
  logic            dom_q;
  logic            pick;

  // Tie goes to the client that was not served last; otherwise whoever asks.
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ~rr_last;
    else if (bus.req1)        pick = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      win     <= 1'b0;
      saddr_q <= 7'h00;
      wd      <= '0;
      cap     <= 8'h00;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      busy_q  <= 1'b0;
      hung_q  <= 1'b0;
      sa_q    <= 7'h00;
      dom_q   <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            win     <= pick;
            saddr_q <= pick ? bus.saddr1 : bus.saddr0;
            busy_q  <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          rr_last <= win;
          if (saddr_q == (win ? SADDR_D1 : SADDR_D0)) begin
            start_q <= 1'b1;
            sa_q    <= saddr_q;
            dom_q   <= win;
            wd      <= '0;
            state   <= GRANT;
          end else begin
            err0_q <= ~win;
            err1_q <= win;
            state  <= DENY;
          end
        end
        GRANT: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done on the expiry cycle still completes normally.
          if (bus.done) begin
            cap    <= bus.read_data;
            ack0_q <= ~win;
            ack1_q <= win;
            sa_q   <= 7'h00;
            dom_q  <= 1'b0;
            state  <= RESP;
          end else if (wd == TO_LAST) begin
            err0_q <= ~win;
            err1_q <= win;
            hung_q <= 1'b1;
            sa_q   <= 7'h00;
            dom_q  <= 1'b0;
            state  <= FAULT;
          end else begin
            wd <= wd + TO_W'(1);
          end
        end
        RESP, DENY: begin
          cap    <= 8'h00;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        FAULT: begin
          // Terminal until reset: requests ignored, downstream left alone.
          state <= FAULT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start      = start_q;
  assign bus.slave_addr = sa_q;
  assign bus.domain_i2c = dom_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.err0       = err0_q;
  assign bus.err1       = err1_q;
  // Captured byte only ever reaches the client whose ack is up.
  assign bus.rdata0     = ack0_q ? cap : 8'h00;
  assign bus.rdata1     = ack1_q ? cap : 8'h00;
  assign bus.busy       = busy_q;
  assign bus.hung       = hung_q;

endmodule

// File: tb/tb_i2c_req_arb.sv
// Purpose: directed, self-checking bench for i2c_req_arb (watchdog shortened to 8 cycles).
// Ports: none; drives the interface instance and compares against hand-computed expectations.
module tb_i2c_req_arb;
  logic clk;
  logic rst_n;
  i2c_req_arb_if bus();

  i2c_req_arb #(.TO_CYC(16'd8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {start, ack0, ack1, err0, err1, busy, hung, domain, slave_addr, rdata0, rdata1}
  function automatic logic [30:0] o(logic st, logic a0, logic a1, logic e0, logic e1,
                                    logic bz, logic hg, logic dm, logic [6:0] sa,
                                    logic [7:0] r0, logic [7:0] r1);
    return {st, a0, a1, e0, e1, bz, hg, dm, sa, r0, r1};
  endfunction

  function automatic logic [30:0] cur();
    return {bus.start, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy, bus.hung,
            bus.domain_i2c, bus.slave_addr, bus.rdata0, bus.rdata1};
  endfunction

  typedef struct {
    logic       req0;
    logic       req1;
    logic [6:0] sa0;
    logic [6:0] sa1;
    logic       done;
    logic [7:0] rd;
    logic [30:0] exp;
  } vec_t;

  vec_t tv[19];

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.saddr0 = 7'h00; bus.saddr1 = 7'h00;
    bus.done = 1'b0; bus.read_data = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bounded wait (from a negedge) for the start pulse.
  task automatic wait_start(input string nm);
    int k;
    k = 0;
    while (!bus.start && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(nm, bus.start, 1'b1);
  endtask

  initial begin
    int n;
    int nst;
    int nack;
    int dcnt;
    int expc;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("reset_outputs", cur(), o(0,0,0,0,0,0,0,0,7'h00,8'h00,8'h00));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Permitted read by client 0, denial of client 1, done ignored in IDLE,
    // done ignored in GRANT, then a permitted read by client 1.
    tv[0]  = '{1,0,7'h10,7'h00,0,8'h00, o(0,0,0,0,0,1,0,0,7'h00,8'h00,8'h00)};
    tv[1]  = '{1,0,7'h10,7'h00,0,8'h00, o(1,0,0,0,0,1,0,0,7'h10,8'h00,8'h00)};
    tv[2]  = '{1,0,7'h10,7'h00,0,8'h00, o(0,0,0,0,0,1,0,0,7'h10,8'h00,8'h00)};
    tv[3]  = '{1,1,7'h10,7'h20,0,8'h00, o(0,0,0,0,0,1,0,0,7'h10,8'h00,8'h00)};
    tv[4]  = '{1,1,7'h10,7'h20,0,8'h00, o(0,0,0,0,0,1,0,0,7'h10,8'h00,8'h00)};
    tv[5]  = '{1,0,7'h10,7'h00,0,8'h00, o(0,0,0,0,0,1,0,0,7'h10,8'h00,8'h00)};
    tv[6]  = '{1,0,7'h10,7'h00,0,8'h00, o(0,0,0,0,0,1,0,0,7'h10,8'h00,8'h00)};
    tv[7]  = '{1,0,7'h10,7'h00,1,8'hA5, o(0,1,0,0,0,1,0,0,7'h00,8'hA5,8'h00)};
    tv[8]  = '{0,0,7'h00,7'h00,0,8'h00, o(0,0,0,0,0,0,0,0,7'h00,8'h00,8'h00)};
    tv[9]  = '{0,0,7'h00,7'h00,0,8'h00, o(0,0,0,0,0,0,0,0,7'h00,8'h00,8'h00)};
    tv[10] = '{0,1,7'h00,7'h10,0,8'h00, o(0,0,0,0,0,1,0,0,7'h00,8'h00,8'h00)};
    tv[11] = '{0,1,7'h00,7'h10,0,8'h00, o(0,0,0,0,1,1,0,0,7'h00,8'h00,8'h00)};
    tv[12] = '{0,0,7'h00,7'h00,0,8'h00, o(0,0,0,0,0,0,0,0,7'h00,8'h00,8'h00)};
    tv[13] = '{0,0,7'h00,7'h00,1,8'hFF, o(0,0,0,0,0,0,0,0,7'h00,8'h00,8'h00)};
    tv[14] = '{0,1,7'h00,7'h20,0,8'h00, o(0,0,0,0,0,1,0,0,7'h00,8'h00,8'h00)};
    tv[15] = '{0,1,7'h00,7'h20,0,8'h00, o(1,0,0,0,0,1,0,1,7'h20,8'h00,8'h00)};
    tv[16] = '{0,1,7'h00,7'h20,1,8'h77, o(0,0,0,0,0,1,0,1,7'h20,8'h00,8'h00)};
    tv[17] = '{0,1,7'h00,7'h20,1,8'h3C, o(0,0,1,0,0,1,0,0,7'h00,8'h00,8'h3C)};
    tv[18] = '{0,0,7'h00,7'h00,0,8'h00, o(0,0,0,0,0,0,0,0,7'h00,8'h00,8'h00)};

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus.req0 = tv[i].req0; bus.req1 = tv[i].req1;
      bus.saddr0 = tv[i].sa0; bus.saddr1 = tv[i].sa1;
      bus.done = tv[i].done; bus.read_data = tv[i].rd;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), cur(), tv[i].exp);
    end

    // Tie from reset: grants alternate 0,1,0,1 with each client re-requesting right after ack.
    do_reset();
    bus.saddr0 = 7'h10; bus.saddr1 = 7'h20;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    nst = 0; nack = 0; dcnt = 0;
    for (int cyc = 0; cyc < 400 && nack < 4; cyc++) begin
      @(negedge clk);
      bus.done = 1'b0;
      if (bus.start) begin
        chk($sformatf("rr_dom%0d", nst), bus.domain_i2c, nst % 2);
        chk($sformatf("rr_sa%0d", nst), bus.slave_addr, (nst % 2) ? 7'h20 : 7'h10);
        nst++;
        dcnt = 3;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          bus.done = 1'b1;
          bus.read_data = 8'h30 + 8'(nack);
        end
      end
      if (bus.ack0 || bus.ack1) begin
        expc = nack % 2;
        chk($sformatf("rr_ack%0d", nack),
            {bus.ack0, bus.ack1, bus.rdata0, bus.rdata1},
            {expc == 0, expc == 1,
             (expc == 0) ? 8'h30 + 8'(nack) : 8'h00,
             (expc == 1) ? 8'h30 + 8'(nack) : 8'h00});
        if (bus.ack0) bus.req0 = 1'b0;
        if (bus.ack1) bus.req1 = 1'b0;
        nack++;
      end else begin
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
      end
    end
    chk("rr_ack_count", nack, 4);

    // Watchdog expiry: 8 WAIT cycles after start, then FAULT with one err0 pulse.
    do_reset();
    bus.req0 = 1'b1; bus.saddr0 = 7'h10;
    @(negedge clk);
    wait_start("wd_start");
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.err0) begin
        n = i;
        break;
      end
    end
    chk("wd_err_delay", n, 9);
    chk("wd_hung_busy", {bus.hung, bus.busy, bus.ack0}, 3'b110);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.saddr1 = 7'h20;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.start || bus.err0 || bus.err1 || bus.ack1 || !bus.hung) n++;
    end
    chk("wd_stuck_ignores_req", n, 0);
    do_reset();
    #1;
    chk("wd_reset_clears_hung", {bus.hung, bus.busy}, 2'b00);

    // Done on the expiry cycle wins over the timeout.
    bus.req0 = 1'b1; bus.saddr0 = 7'h10;
    @(negedge clk);
    wait_start("col_start");
    for (int i = 1; i <= 8; i++) @(negedge clk);
    bus.done = 1'b1; bus.read_data = 8'h5A;
    @(negedge clk);
    bus.done = 1'b0;
    chk("col_ack", {bus.ack0, bus.err0, bus.hung, bus.rdata0, bus.rdata1},
        {1'b1, 1'b0, 1'b0, 8'h5A, 8'h00});
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("col_after", {bus.hung, bus.busy}, 2'b00);

    // Reset in the middle of WAIT, then a fresh read completes.
    bus.req0 = 1'b1; bus.saddr0 = 7'h10;
    @(negedge clk);
    wait_start("rst_start");
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_wait", {bus.busy, bus.slave_addr}, {1'b1, 7'h10});
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", cur(), o(0,0,0,0,0,0,0,0,7'h00,8'h00,8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_start("rst_restart");
    chk("rst_restart_sa", {bus.slave_addr, bus.domain_i2c}, {7'h10, 1'b0});
    @(negedge clk);
    @(negedge clk);
    bus.done = 1'b1; bus.read_data = 8'hC3;
    @(negedge clk);
    bus.done = 1'b0;
    chk("rst_restart_ack", {bus.ack0, bus.rdata0, bus.rdata1}, {1'b1, 8'hC3, 8'h00});
    bus.req0 = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
